// File: rtl/mul_pkg.sv
// Shared types and default parameters for the operand-entry / multiply controller.
package mul_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        MULT   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    localparam int DEF_W               = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/mul_operand_seq_if.sv
// Switch/button inputs and LED/status outputs of the operand-entry controller.
interface mul_operand_seq_if #(
    parameter int W = 4
);
    logic [W-1:0]   s;
    logic           button;
    logic [W-1:0]   out;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    logic [1:0]     state_o;

    modport master (
        output s, button,
        input  out, product, busy, done, state_o
    );

    modport slave (
        input  s, button,
        output out, product, busy, done, state_o
    );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge detector for a bouncy button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg, sync2_reg;
    logic          level_reg, level_d_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= button;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            // The level flips on the Nth consecutive cycle of disagreement.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/mul_operand_seq.sv
// Operand entry FSM: latch A and B on button presses, shift-add multiply, show product by nibble.
module mul_operand_seq
    import mul_pkg::*;
#(
    parameter int W               = DEF_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    mul_operand_seq_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [2*W-1:0] acc_reg, acc_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*W-1:0] product_reg, product_next;
    logic           nib_reg, nib_next;
    logic [W-1:0]   out_reg, out_next;
    logic           done_reg, done_next;
    logic           press;
    logic [2*W-1:0] pp [W];
    logic [2*W-1:0] acc_sum;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (bus.button),
        .level  (),
        .press  (press)
    );

    // Partial products A << i, selected by the bit counter during MULT.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pp
            assign pp[gi] = {{W{1'b0}}, a_reg} << gi;
        end
    endgenerate

    assign acc_sum = acc_reg + (b_reg[cnt_reg] ? pp[cnt_reg] : '0);

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        nib_next     = nib_reg;
        out_next     = out_reg;
        done_next    = 1'b0;
        case (state_reg)
            LOAD_A: begin
                out_next = bus.s;
                if (press) begin
                    a_next     = bus.s;
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                out_next = bus.s;
                if (press) begin
                    b_next     = bus.s;
                    acc_next   = '0;
                    cnt_next   = '0;
                    out_next   = '0;
                    state_next = MULT;
                end
            end
            MULT: begin
                out_next = '0;
                acc_next = acc_sum;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(W - 1)) begin
                    product_next = acc_sum;
                    nib_next     = 1'b0;
                    out_next     = acc_sum[W-1:0];
                    done_next    = 1'b1;
                    state_next   = SHOW;
                end
            end
            SHOW: begin
                out_next = nib_reg ? product_reg[2*W-1:W] : product_reg[W-1:0];
                if (press) begin
                    if (!nib_reg) begin
                        nib_next = 1'b1;
                        out_next = product_reg[2*W-1:W];
                    end else begin
                        a_next       = '0;
                        b_next       = '0;
                        product_next = '0;
                        nib_next     = 1'b0;
                        out_next     = bus.s;
                        state_next   = LOAD_A;
                    end
                end
            end
            default: state_next = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= LOAD_A;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            nib_reg     <= 1'b0;
            out_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            nib_reg     <= nib_next;
            out_reg     <= out_next;
            done_reg    <= done_next;
        end
    end

    assign bus.out     = out_reg;
    assign bus.product = product_reg;
    assign bus.busy    = (state_reg == MULT);
    assign bus.done    = done_reg;
    assign bus.state_o = state_reg;

endmodule

// File: tb/tb_mul_operand_seq.sv
// Randomized self-checking bench: expected products and nibbles come from plain arithmetic.
module tb_mul_operand_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mul_operand_seq_if #(.W(4)) bus ();
    mul_operand_seq_if #(.W(4)) bus_f ();

    mul_operand_seq #(.W(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Fast-debounce copy lets a second press land inside the 4-cycle MULT window.
    mul_operand_seq #(.W(4), .DEBOUNCE_CYCLES(1)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_press(input logic [3:0] sv, output int nbusy, output int ndone,
                            output logic [7:0] pd, output logic [3:0] od);
        nbusy = 0; ndone = 0; pd = '0; od = '0;
        bus.s = sv;
        for (int i = 0; i < 18; i++) begin
            bus.button = (i < 8);
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                pd = bus.product;
                od = bus.out;
            end
        end
    endtask

    task automatic run_mul(input int a, input int b);
        int nb, nd, p;
        logic [7:0] pd;
        logic [3:0] od;
        p = a * b;
        do_press(4'(a), nb, nd, pd, od);
        check("loadA_state", int'(bus.state_o), 1);
        check("loadB_out", int'(bus.out), a);
        do_press(4'(b), nb, nd, pd, od);
        check("busy_cycles", nb, 4);
        check("done_pulses", nd, 1);
        check("product_at_done", int'(pd), p);
        check("out_low_at_done", int'(od), p % 16);
        check("show_state", int'(bus.state_o), 3);
        check("show_out_low", int'(bus.out), p % 16);
        do_press(4'(0), nb, nd, pd, od);
        check("show_out_high", int'(bus.out), p / 16);
        check("show_state2", int'(bus.state_o), 3);
        do_press(4'(0), nb, nd, pd, od);
        check("back_loadA", int'(bus.state_o), 0);
        check("product_cleared", int'(bus.product), 0);
        $display("[TB] mul %0d x %0d expect %0h", a, b, p);
    endtask

    initial begin
        int changes, p, a, b, waited;
        int pat [17] = '{1,1,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0};
        int fpat [10] = '{1,0,1,1,1,1,0,0,0,0};
        logic [1:0] st0;

        rst = 1'b1;
        bus.s = '0; bus.button = 1'b0;
        bus_f.s = '0; bus_f.button = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", int'(bus.out), 0);
        check("rst_product", int'(bus.product), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_state", int'(bus.state_o), 0);

        run_mul(3, 5);
        run_mul(15, 15);
        run_mul(0, 9);
        for (int k = 0; k < 4; k++) run_mul(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // Bounce never reaches the stability count.
        changes = 0;
        st0 = bus.state_o;
        for (int i = 0; i < 17; i++) begin
            bus.button = pat[i][0];
            @(negedge clk);
            if (bus.state_o != st0) changes++;
        end
        check("bounce_no_change", changes, 0);
        check("bounce_state", int'(bus.state_o), 0);
        $display("[TB] bounce pattern state changes %0d", changes);
        bus.s = 4'd7;
        for (int i = 0; i < 16; i++) begin
            bus.button = (i < 6);
            @(negedge clk);
        end
        check("stable_press_state", int'(bus.state_o), 1);

        // Reset in the middle of a multiply, with the button still held.
        bus.s = 4'd9;
        bus.button = 1'b1;
        waited = 0;
        while (!bus.busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("midmult_reached", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", int'(bus.state_o), 0);
        check("midrst_product", int'(bus.product), 0);
        check("midrst_busy", int'(bus.busy), 0);
        $display("[TB] reset during MULT -> state %0d", bus.state_o);
        repeat (12) @(negedge clk);
        bus.button = 1'b0;
        repeat (12) @(negedge clk);
        check("held_thru_rst_press", int'(bus.state_o), 1);

        // Press pulse arriving while the fast instance is multiplying is dropped.
        a = int'($urandom_range(1, 15));
        b = int'($urandom_range(1, 15));
        p = a * b;
        bus_f.s = 4'(a);
        for (int i = 0; i < 7; i++) begin
            bus_f.button = (i < 3);
            @(negedge clk);
        end
        check("fast_loadA", int'(bus_f.state_o), 1);
        bus_f.s = 4'(b);
        for (int i = 0; i < 10; i++) begin
            bus_f.button = fpat[i][0];
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("drop_state", int'(bus_f.state_o), 3);
        check("drop_product", int'(bus_f.product), p);
        check("drop_out_low", int'(bus_f.out), p % 16);
        $display("[TB] press during MULT %0d x %0d -> %0h", a, b, bus_f.product);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
